// File: rtl/car_sensor_stim.sv
// Gate-sensor sequence generator: drives b1/b2 through entry, exit and pedestrian
// patterns with a programmable dwell per phase, and tallies completed entries/exits.
module car_sensor_stim #(
  parameter int unsigned PHASE_CYCLES = 10,
  parameter int unsigned CNT_W        = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       kind,
  output logic             b1,
  output logic             b2,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] entries,
  output logic [CNT_W-1:0] exits
);

  localparam int unsigned PH_W = $clog2(PHASE_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PH1  = 3'd1,
    PH2  = 3'd2,
    PH3  = 3'd3,
    GAP  = 3'd4
  } state_t;

  state_t            state, state_n;
  logic [1:0]        kind_q, kind_n;
  logic [PH_W-1:0]   cnt, cnt_n;
  logic              b1_n, b2_n, busy_n, done_n;
  logic              ent_inc, ex_inc;

  // State, latched kind, phase timer and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      kind_q  <= 2'b00;
      cnt     <= '0;
      b1      <= 1'b0;
      b2      <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      entries <= '0;
      exits   <= '0;
    end else begin
      state  <= state_n;
      kind_q <= kind_n;
      cnt    <= cnt_n;
      b1     <= b1_n;
      b2     <= b2_n;
      busy   <= busy_n;
      done   <= done_n;
      if (ent_inc) entries <= entries + CNT_W'(1);
      if (ex_inc)  exits   <= exits + CNT_W'(1);
    end
  end

  // Next state, phase timing and next output values
  always_comb begin
    state_n = state;
    kind_n  = kind_q;
    cnt_n   = (cnt != '0) ? cnt - PH_W'(1) : cnt;
    done_n  = 1'b0;
    ent_inc = 1'b0;
    ex_inc  = 1'b0;
    b1_n    = 1'b0;
    b2_n    = 1'b0;

    unique case (state)
      IDLE: begin
        if (start) begin
          state_n = PH1;
          kind_n  = kind;
        end
      end
      PH1: begin
        // Pedestrian patterns have no overlap phase
        if (cnt == '0) state_n = kind_q[1] ? PH3 : PH2;
      end
      PH2: begin
        if (cnt == '0) state_n = PH3;
      end
      PH3: begin
        if (cnt == '0) state_n = GAP;
      end
      GAP: begin
        if (cnt == '0) begin
          state_n = IDLE;
          done_n  = 1'b1;
          ent_inc = (kind_q == 2'b00);
          ex_inc  = (kind_q == 2'b01);
        end
      end
      default: state_n = IDLE;
    endcase

    if (state_n != state) cnt_n = PH_W'(PHASE_CYCLES - 1);

    // kind[0] selects which sensor trips first
    unique case (state_n)
      PH1: begin
        b1_n = ~kind_n[0];
        b2_n = kind_n[0];
      end
      PH2: begin
        b1_n = 1'b1;
        b2_n = 1'b1;
      end
      PH3: begin
        b1_n = kind_n[0];
        b2_n = ~kind_n[0];
      end
      default: begin
        b1_n = 1'b0;
        b2_n = 1'b0;
      end
    endcase

    busy_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_car_sensor_stim.sv
// Directed bench for car_sensor_stim with PHASE_CYCLES=2, CNT_W=3.
module tb_car_sensor_stim;

  logic       clk;
  logic       reset;
  logic       start;
  logic [1:0] kind;
  logic       b1, b2, busy, done;
  logic [2:0] entries, exits;

  int n_checks = 0;
  int n_errors = 0;

  car_sensor_stim #(.PHASE_CYCLES(2), .CNT_W(3)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .kind    (kind),
    .b1      (b1),
    .b2      (b2),
    .busy    (busy),
    .done    (done),
    .entries (entries),
    .exits   (exits)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hand-written (b1,b2) pattern for each kind, one entry per phase
  function automatic logic [1:0] exp_bits(input logic [1:0] k, input int seg);
    logic [1:0] t_ent [4];
    logic [1:0] t_ex  [4];
    logic [1:0] t_pf  [3];
    logic [1:0] t_pr  [3];
    t_ent = '{2'b10, 2'b11, 2'b01, 2'b00};
    t_ex  = '{2'b01, 2'b11, 2'b10, 2'b00};
    t_pf  = '{2'b10, 2'b01, 2'b00};
    t_pr  = '{2'b01, 2'b10, 2'b00};
    case (k)
      2'b00:   return t_ent[seg];
      2'b01:   return t_ex[seg];
      2'b10:   return t_pf[seg];
      default: return t_pr[seg];
    endcase
  endfunction

  // Starts a sequence and checks every cycle up to and including the done cycle.
  // poke: offset at whose edge a stray start/kind=01 is sampled (-1 = none).
  task automatic run_seq(input logic [1:0] k, input int poke, input bit hold,
                         input logic [2:0] ent, input logic [2:0] ex);
    int len;
    len = k[1] ? 6 : 8;
    start = 1'b1;
    kind  = k;
    tick();
    if (!hold) start = 1'b0;
    for (int offs = 0; offs <= len; offs++) begin
      if (offs < len) begin
        check($sformatf("k%0d_bits@%0d", k, offs), {30'd0, b1, b2}, {30'd0, exp_bits(k, offs / 2)});
        check($sformatf("k%0d_busy@%0d", k, offs), {31'd0, busy}, 32'd1);
        check($sformatf("k%0d_done@%0d", k, offs), {31'd0, done}, 32'd0);
      end else begin
        check($sformatf("k%0d_idle_bits", k), {30'd0, b1, b2}, 32'd0);
        check($sformatf("k%0d_end_busy", k), {31'd0, busy}, 32'd0);
        check($sformatf("k%0d_end_done", k), {31'd0, done}, 32'd1);
        check($sformatf("k%0d_entries", k), {29'd0, entries}, {29'd0, ent});
        check($sformatf("k%0d_exits", k), {29'd0, exits}, {29'd0, ex});
      end
      if (!hold) begin
        start = (offs == poke - 1);
        kind  = (offs == poke - 1) ? 2'b01 : k;
      end
      if (offs < len) tick();
    end
  endtask

  initial begin
    int waited;
    reset = 1'b0;
    start = 1'b0;
    kind  = 2'b00;
    repeat (5) @(posedge clk);
    #1;
    check("rst_b1b2", {30'd0, b1, b2}, 32'd0);
    check("rst_busy_done", {30'd0, busy, done}, 32'd0);
    reset = 1'b1;
    repeat (4) tick();
    check("idle_b1b2", {30'd0, b1, b2}, 32'd0);
    check("idle_busy_done", {30'd0, busy, done}, 32'd0);
    check("idle_tallies", {26'd0, entries, exits}, 32'd0);

    run_seq(2'b00, -1, 1'b0, 3'd1, 3'd0);
    tick();
    check("done_one_cycle", {31'd0, done}, 32'd0);
    run_seq(2'b01, -1, 1'b0, 3'd1, 3'd1);
    run_seq(2'b10, -1, 1'b0, 3'd1, 3'd1);
    run_seq(2'b11, -1, 1'b0, 3'd1, 3'd1);

    // Stray exit request at k+3 must be ignored
    run_seq(2'b00, 3, 1'b0, 3'd2, 3'd1);

    // Held start: back-to-back entries separated by the single IDLE cycle
    run_seq(2'b00, -1, 1'b1, 3'd3, 3'd1);
    tick();
    check("b2b_ph1_bits", {30'd0, b1, b2}, 32'b10);
    check("b2b_ph1_busy", {31'd0, busy}, 32'd1);
    start = 1'b0;
    waited = 0;
    while (!done && waited < 20) begin
      tick();
      waited++;
    end
    check("b2b_done_seen", {31'd0, done}, 32'd1);
    check("b2b_latency", waited, 32'd8);
    check("b2b_entries", {29'd0, entries}, 32'd4);

    // Wrap: reset tallies, then eight entries read 1..7,0
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst2_tallies", {26'd0, entries, exits}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    for (int i = 1; i <= 8; i++) run_seq(2'b00, -1, 1'b0, 3'(i), 3'd0);

    // Reset mid-entry aborts without done or tally
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    tick();
    start = 1'b1;
    kind  = 2'b00;
    tick();
    start = 1'b0;
    repeat (3) tick();
    check("pre_abort_bits", {30'd0, b1, b2}, 32'b11);
    reset = 1'b0;
    #1;
    check("abort_bits", {30'd0, b1, b2}, 32'd0);
    check("abort_busy_done", {30'd0, busy, done}, 32'd0);
    check("abort_entries", {29'd0, entries}, 32'd0);
    waited = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done) waited++;
    end
    check("abort_no_done", waited, 32'd0);
    reset = 1'b1;
    tick();
    check("post_abort_idle", {28'd0, b1, b2, busy, done}, 32'd0);
    run_seq(2'b00, -1, 1'b0, 3'd1, 3'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
